// File: rtl/run_controller_if.sv
// Run-control bus: restart/halt requests toward the controller, reset/status outputs back.
// The controller takes the slave modport; the harness driving it takes the master modport.
interface run_controller_if #(
    parameter int NUM_DOMAINS = 2,
    parameter int COUNT_WIDTH = 32
);
    logic                   restart_in;
    logic                   halt_in;
    logic [NUM_DOMAINS-1:0] domain_reset_out;
    logic [COUNT_WIDTH-1:0] cycle_count;
    logic                   running;
    logic                   done;
    logic                   timeout;

    modport master (
        output restart_in,
        output halt_in,
        input  domain_reset_out,
        input  cycle_count,
        input  running,
        input  done,
        input  timeout
    );

    modport slave (
        input  restart_in,
        input  halt_in,
        output domain_reset_out,
        output cycle_count,
        output running,
        output done,
        output timeout
    );
endinterface

// File: rtl/run_controller.sv
// Run controller: holds NUM_DOMAINS resets, releases them staggered, counts run cycles and ends
// the run on halt or budget expiry. Optional RUN_CTRL_SIM_STOP_EN adds a simulation stop at run end.
module run_controller #(
    parameter int NUM_DOMAINS    = 2,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGGER_CYCLES = 2,
    parameter int RUN_BUDGET     = 50,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic             clock,
    input  logic             reset,
    run_controller_if.slave  ctrl
);
    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int STAG_MAX = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES : 1;
    localparam int STAG_W   = (STAG_MAX > 1) ? $clog2(STAG_MAX + 1) : 1;
    localparam int IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0]      STAG_LAST = STAG_W'(STAG_MAX - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] BUDGET    = COUNT_WIDTH'(RUN_BUDGET);
    // With a single domain or no stagger, every domain leaves reset on the last HOLD edge.
    localparam bit DIRECT_RUN = (NUM_DOMAINS == 1) || (STAGGER_CYCLES == 0);

    state_t                 state_reg, state_next;
    logic [HOLD_W-1:0]      hold_cnt_reg, hold_cnt_next;
    logic [STAG_W-1:0]      stag_cnt_reg, stag_cnt_next;
    logic [IDX_W-1:0]       dom_idx_reg, dom_idx_next;
    logic [NUM_DOMAINS-1:0] domain_reset_reg, domain_reset_next;
    logic [COUNT_WIDTH-1:0] cycle_count_reg, cycle_count_next;
    logic                   running_reg, running_next;
    logic                   done_reg, done_next;
    logic                   timeout_reg, timeout_next;

    logic                   restart;
    logic                   halt;
    logic                   hold_done;
    logic                   step_done;
    logic                   last_step;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   budget_hit;

    assign restart    = ctrl.restart_in;
    assign halt       = ctrl.halt_in;
    assign hold_done  = (state_reg == ST_HOLD) && (hold_cnt_reg == HOLD_LAST);
    assign step_done  = (state_reg == ST_RELEASE) && (stag_cnt_reg == STAG_LAST);
    assign last_step  = step_done && (dom_idx_reg == IDX_LAST);
    assign count_inc  = (cycle_count_reg == COUNT_MAX) ? cycle_count_reg
                                                       : cycle_count_reg + COUNT_WIDTH'(1);
    assign budget_hit = (RUN_BUDGET != 0) && (count_inc == BUDGET);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_HOLD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (restart) begin
            state_next = ST_HOLD;
        end else begin
            case (state_reg)
                ST_HOLD:    if (hold_done) state_next = DIRECT_RUN ? ST_RUN : ST_RELEASE;
                ST_RELEASE: if (last_step) state_next = ST_RUN;
                ST_RUN:     if (halt || budget_hit) state_next = ST_DONE;
                default:    state_next = state_reg;
            endcase
        end
    end

    // Each domain has its own release condition; once released it stays released until restart.
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
        logic release_now;
        if (gi == 0 || STAGGER_CYCLES == 0) begin : g_first
            assign release_now = hold_done;
        end else begin : g_staggered
            assign release_now = step_done && (dom_idx_reg == IDX_W'(gi));
        end
        assign domain_reset_next[gi] = restart     ? 1'b1 :
                                       release_now ? 1'b0 : domain_reset_reg[gi];
    end

    always_comb begin
        hold_cnt_next    = hold_cnt_reg;
        stag_cnt_next    = stag_cnt_reg;
        dom_idx_next     = dom_idx_reg;
        cycle_count_next = cycle_count_reg;
        running_next     = running_reg;
        done_next        = done_reg;
        timeout_next     = timeout_reg;
        if (restart) begin
            hold_cnt_next    = '0;
            stag_cnt_next    = '0;
            dom_idx_next     = '0;
            cycle_count_next = '0;
            running_next     = 1'b0;
            done_next        = 1'b0;
            timeout_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (hold_done) begin
                        hold_cnt_next = '0;
                        dom_idx_next  = IDX_W'(1);
                        running_next  = DIRECT_RUN;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (step_done) begin
                        stag_cnt_next = '0;
                        dom_idx_next  = dom_idx_reg + IDX_W'(1);
                        if (last_step) running_next = 1'b1;
                    end else begin
                        stag_cnt_next = stag_cnt_reg + STAG_W'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count_next = count_inc;
                    // A halt on the expiry edge still reports a requested stop, not a timeout.
                    if (halt) begin
                        done_next    = 1'b1;
                        timeout_next = 1'b0;
                        running_next = 1'b0;
                    end else if (budget_hit) begin
                        done_next    = 1'b1;
                        timeout_next = 1'b1;
                        running_next = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt_reg     <= '0;
            stag_cnt_reg     <= '0;
            dom_idx_reg      <= '0;
            domain_reset_reg <= '1;
            cycle_count_reg  <= '0;
            running_reg      <= 1'b0;
            done_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            hold_cnt_reg     <= hold_cnt_next;
            stag_cnt_reg     <= stag_cnt_next;
            dom_idx_reg      <= dom_idx_next;
            domain_reset_reg <= domain_reset_next;
            cycle_count_reg  <= cycle_count_next;
            running_reg      <= running_next;
            done_reg         <= done_next;
            timeout_reg      <= timeout_next;
        end
    end

    assign ctrl.domain_reset_out = domain_reset_reg;
    assign ctrl.cycle_count      = cycle_count_reg;
    assign ctrl.running          = running_reg;
    assign ctrl.done             = done_reg;
    assign ctrl.timeout          = timeout_reg;

`ifdef RUN_CTRL_SIM_STOP_EN
`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && !restart && state_reg == ST_RUN && state_next == ST_DONE) begin
            $display("run end: cycles=%0d timeout=%0b", count_inc, timeout_next);
            $stop;
        end
    end
`endif
`else
    // Without the simulation stop the block contains no system tasks.
`endif

endmodule
